// File: rtl/multicore_cpu_mul_combine.sv
// multicore_cpu_mul_combine
// Reduces the four 16x16 partial products from the per-core multiplier cell
// into the low or high 32-bit word of the 64-bit product. There are two
// stall-aware stages:
//   S1: the low-word add, which is 34 bits wide to keep the carry, plus
//       sign-extended capture of the upper halves of p2 and p3.
//   S2: the high-word four-operand add, folding in the S1 carry, then the
//       word select.
// The valid bits follow the data through both stages. A flush kills the
// valid bits only; the data registers keep whatever they held.

module multicore_cpu_mul_combine (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    input  logic [31:0] M_mul_cell_p4,
    input  logic        M_src1_signed,
    input  logic        M_src2_signed,
    input  logic        M_mul_hi,
    input  logic        M_mul_valid,
    input  logic        A_en,
    input  logic        A_flush,
    output logic [31:0] A_mul_result,
    output logic        A_mul_result_valid,
    output logic        A_mul_busy
);

    logic [33:0] lo_sum;
    logic [31:0] p2_hi_ext;
    logic [31:0] p3_hi_ext;
    logic [31:0] hi_sum;

    logic [31:0] s1_lo;
    logic [1:0]  s1_carry;
    logic [31:0] s1_p2h;
    logic [31:0] s1_p3h;
    logic [31:0] s1_p4;
    logic        s1_hi_sel;
    logic        s1_valid;

    // S1 combinational: the low word of the product, and the upper halves of the cross terms
    always_comb begin
        lo_sum = {2'b00, M_mul_cell_p1}
               + {2'b00, M_mul_cell_p2[15:0], 16'h0000}
               + {2'b00, M_mul_cell_p3[15:0], 16'h0000};
        // A cross term is negative only when its high-half operand is signed.
        p2_hi_ext = {{16{M_src2_signed & M_mul_cell_p2[31]}}, M_mul_cell_p2[31:16]};
        p3_hi_ext = {{16{M_src1_signed & M_mul_cell_p3[31]}}, M_mul_cell_p3[31:16]};
    end

    // S1 registers: data advances on enable; valid is also cleared by flush
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_lo     <= 32'h0;
            s1_carry  <= 2'b00;
            s1_p2h    <= 32'h0;
            s1_p3h    <= 32'h0;
            s1_p4     <= 32'h0;
            s1_hi_sel <= 1'b0;
            s1_valid  <= 1'b0;
        end else begin
            if (A_en) begin
                s1_lo     <= lo_sum[31:0];
                s1_carry  <= lo_sum[33:32];
                s1_p2h    <= p2_hi_ext;
                s1_p3h    <= p3_hi_ext;
                s1_p4     <= M_mul_cell_p4;
                s1_hi_sel <= M_mul_hi;
            end
            if (A_flush) begin
                s1_valid <= 1'b0;
            end else if (A_en) begin
                s1_valid <= M_mul_valid;
            end
        end
    end

    // S2 combinational: the high word, with the low-word carry folded in
    always_comb begin
        hi_sum = s1_p4 + s1_p2h + s1_p3h + {30'h0, s1_carry};
    end

    // S2 registers: select the result word; valid is also cleared by flush
    always_ff @(posedge clk) begin
        if (reset) begin
            A_mul_result       <= 32'h0;
            A_mul_result_valid <= 1'b0;
        end else begin
            if (A_en) begin
                A_mul_result <= s1_hi_sel ? hi_sum : s1_lo;
            end
            if (A_flush) begin
                A_mul_result_valid <= 1'b0;
            end else if (A_en) begin
                A_mul_result_valid <= s1_valid;
            end
        end
    end

    assign A_mul_busy = s1_valid;

endmodule

// File: tb/tb_multicore_cpu_mul_combine.sv
// Testbench for multicore_cpu_mul_combine.
// The bench derives the partial products from the operands and takes the
// expected result from a 64-bit reference product. A scoreboard queue holds
// the expected results. A negedge monitor pops from that queue and compares
// whenever the DUT shows a new result.

module tb_multicore_cpu_mul_combine;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p1, p2, p3, p4;
    logic        s1_signed, s2_signed, mul_hi, mul_valid, en, flush;
    logic [31:0] result;
    logic        result_valid, busy;

    always #5 clk = ~clk;

    multicore_cpu_mul_combine dut (
        .clk                (clk),
        .reset              (reset),
        .M_mul_cell_p1      (p1),
        .M_mul_cell_p2      (p2),
        .M_mul_cell_p3      (p3),
        .M_mul_cell_p4      (p4),
        .M_src1_signed      (s1_signed),
        .M_src2_signed      (s2_signed),
        .M_mul_hi           (mul_hi),
        .M_mul_valid        (mul_valid),
        .A_en               (en),
        .A_flush            (flush),
        .A_mul_result       (result),
        .A_mul_result_valid (result_valid),
        .A_mul_busy         (busy)
    );

    typedef struct {
        logic [31:0] val;
        int          edge_idx;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          edge_cnt = 0;
    int          kind = -1;        // 0 reset, 1 flush, 2 enabled, 3 stalled
    logic        busy_exp = 1'b0;
    logic [31:0] cur_exp = 32'h0;
    logic [31:0] prev_res = 32'h0;
    logic        prev_v = 1'b0;
    logic        prev_b = 1'b0;

    // Reference result: extend both operands to 64 bits, multiply, pick a word.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic h);
        logic [63:0] ea, eb, prod;
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        prod = ea * eb;
        return h ? prod[63:32] : prod[31:0];
    endfunction

    // Drive one cycle's worth of inputs, building the cell's partial products from the operands.
    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                          input logic h, input logic v, input logic e, input logic f,
                          input logic [31:0] k);
        logic [63:0] ah, bh, al, bl, t;
        al = {48'h0, a[15:0]};
        bl = {48'h0, b[15:0]};
        ah = sa ? {{48{a[31]}}, a[31:16]} : {48'h0, a[31:16]};
        bh = sb ? {{48{b[31]}}, b[31:16]} : {48'h0, b[31:16]};
        t = al * bl; p1 = t[31:0];
        t = al * bh; p2 = t[31:0];
        t = ah * bl; p3 = t[31:0];
        t = ah * bh; p4 = t[31:0];
        s1_signed = sa;
        s2_signed = sb;
        mul_hi    = h;
        mul_valid = v;
        en        = e;
        flush     = f;
        cur_exp   = k;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
    endtask

    // Edge tracker: records what each clock edge did and keeps the scoreboard in step.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                sb_q.delete();
                busy_exp = 1'b0;
                kind = 0;
            end else if (flush) begin
                // Every unreported multiply is in flight, so a flush discards all of them.
                sb_q.delete();
                busy_exp = 1'b0;
                kind = 1;
            end else if (en) begin
                edge_cnt++;
                if (mul_valid) sb_q.push_back('{cur_exp, edge_cnt});
                busy_exp = mul_valid;
                kind = 2;
            end else begin
                kind = 3;
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (kind)
                0: begin
                    tests++;
                    if (result !== 32'h0 || result_valid !== 1'b0 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL reset_state: result=%h valid=%b busy=%b, required 00000000/0/0",
                                 result, result_valid, busy);
                    end
                end
                1: begin
                    tests++;
                    if (result_valid !== 1'b0 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL flush_kill: valid=%b busy=%b, required 0/0", result_valid, busy);
                    end
                end
                3: begin
                    tests++;
                    if (result !== prev_res || result_valid !== prev_v || busy !== prev_b) begin
                        fails++;
                        $display("FAIL stall_hold: result=%h valid=%b busy=%b, required %h/%b/%b",
                                 result, result_valid, busy, prev_res, prev_v, prev_b);
                    end
                end
                2: begin
                    tests++;
                    if (busy !== busy_exp) begin
                        fails++;
                        $display("FAIL busy: got %b, required %b", busy, busy_exp);
                    end
                    if (result_valid === 1'b1) begin
                        tests++;
                        if (sb_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_valid: result=%h, no result required", result);
                        end else begin
                            e = sb_q.pop_front();
                            if (result !== e.val) begin
                                fails++;
                                $display("FAIL result: got %h, required %h", result, e.val);
                            end
                            tests++;
                            // The capture edge is the first edge; the result shows after the second one.
                            if (edge_cnt != e.edge_idx + 1) begin
                                fails++;
                                $display("FAIL latency: got %0d edges, required 2", edge_cnt - e.edge_idx + 1);
                            end
                        end
                    end else if (sb_q.size() != 0 && sb_q[0].edge_idx + 1 <= edge_cnt) begin
                        tests++;
                        fails++;
                        e = sb_q.pop_front();
                        $display("FAIL missing_result: valid=%b, required 1 with %h", result_valid, e.val);
                    end
                end
                default: ;
            endcase
            prev_res = result;
            prev_v   = result_valid;
            prev_b   = busy;
        end
    end

    // Stimulus
    initial begin
        logic [31:0] a, b;
        logic        sa, sb, h, v, e, f;
        int          combo;

        reset = 1'b1;
        set_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();
        reset = 1'b0;
        idle(2);

        // Directed cases, with hand-derived expected words.
        set_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd15); tick();
        idle(3);
        set_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE); tick();
        set_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000001); tick();
        set_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000); tick();
        set_op(32'hFFFFFFFE, 32'd3,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF); tick();
        set_op(32'hFFFFFFFE, 32'd3,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFA); tick();
        idle(3);

        // Back-to-back issue, then a three-cycle stall while S2 holds a result.
        set_op(32'd7,  32'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd63);  tick();
        set_op(32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd143); tick();
        set_op(32'd17, 32'd19, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd323); tick();
        for (int i = 0; i < 3; i++) begin
            set_op(32'd99, 32'd99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF); tick();
        end
        idle(3);

        // A flush while a multiply sits in S1, then a fresh multiply that must complete.
        set_op(32'd100, 32'd200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd20000); tick();
        set_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0); tick();
        set_op(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd42); tick();
        idle(3);
        // A flush in the same cycle as a new multiply: nothing is captured.
        set_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd25); tick();
        idle(3);

        // Reset with two multiplies in flight: no stale pulse afterwards.
        set_op(32'd21, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd42); tick();
        set_op(32'd22, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd44); tick();
        reset = 1'b1;
        set_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick(); tick();
        reset = 1'b0;
        idle(4);

        // Randomized cross-check over the four operation kinds, with random stalls, bubbles and flushes.
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = $urandom;
            combo = $urandom_range(0, 3);
            case (combo)
                0:       begin sa = 1'b0; sb = 1'b0; h = 1'b0; end
                1:       begin sa = 1'b1; sb = 1'b1; h = 1'b1; end
                2:       begin sa = 1'b1; sb = 1'b0; h = 1'b1; end
                default: begin sa = 1'b0; sb = 1'b0; h = 1'b1; end
            endcase
            v = ($urandom_range(0, 7) != 0);
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 63) == 0);
            set_op(a, b, sa, sb, h, v, e, f, ref_mul(a, b, sa, sb, h));
            tick();
        end

        idle(5);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicore_cpu_mul_combine.md
# multicore_cpu_mul_combine

Consumer stage for the per-core 16x16 partial-product multiplier cell. It takes the four registered partial products (p1 = lo×lo, p2 = lo×hi, p3 = hi×lo, p4 = hi×hi) and the operand sign controls. It reduces them over a two-stage stall-aware pipeline into the 32-bit result of mul (low word) or mulxss/mulxsu/mulxuu (high word), and presents that result to the A/W writeback path with a valid flag.

## Interface
- No parameters; all widths are fixed at 32-bit data and 16-bit halves.
- clk  in  1  core clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- M_mul_cell_p1  in  32  unsigned product src1[15:0]×src2[15:0].
- M_mul_cell_p2  in  32  product src1[15:0]×src2[31:16]; signed if M_src2_signed.
- M_mul_cell_p3  in  32  product src1[31:16]×src2[15:0]; signed if M_src1_signed.
- M_mul_cell_p4  in  32  product src1[31:16]×src2[31:16], using the same signedness controls.
- M_src1_signed  in  1  src1 treated as signed.
- M_src2_signed  in  1  src2 treated as signed.
- M_mul_hi  in  1  1 = return bits [63:32]; 0 = return bits [31:0].
- M_mul_valid  in  1  partial products for a multiply instruction are present this cycle.
- A_en  in  1  pipeline advance enable; 0 = stall and hold all stages.
- A_flush  in  1  kill all in-flight multiplies.
- A_mul_result  out  32  selected result word.
- A_mul_result_valid  out  1  A_mul_result holds a completed multiply.
- A_mul_busy  out  1  a multiply is in stage 1 (stage-2 result not yet available).

## Operation
- Extension rules:
  - ext(p2) is the sign-extension of p2 when M_src2_signed=1, otherwise zero-extension.
  - ext(p3) uses M_src1_signed in the same way.
  - p4 needs no extension; only its low 32 bits contribute.
- Stage 1 (S1) captures when A_en=1.
  - Low sum: lo33 = p1 + {p2[15:0],16'h0} + {p3[15:0],16'h0}, computed at 34 bits.
  - Registered values: S1_lo = lo33[31:0] and S1_carry = lo33[33:32] (range 0..2).
  - Also registered: S1_p2h = ext(p2)[47:32]‖p2[31:16] as a 32-bit extended upper half, S1_p3h likewise, S1_p4 = p4, S1_hi_sel = M_mul_hi, and S1_valid = M_mul_valid.
- Stage 2 (S2) captures when A_en=1.
  - hi = S1_p4 + S1_p2h + S1_p3h + S1_carry, modulo 2^32.
  - A_mul_result = S1_hi_sel ? hi : S1_lo.
  - A_mul_result_valid = S1_valid.
- Stall: while A_en=0, every register (data and valid) holds. Input changes during a stall are ignored.
- Flush:
  - A_flush=1 clears S1_valid and A_mul_result_valid at the next edge, regardless of A_en.
  - Data registers may keep their contents.
  - Flush and a new M_mul_valid in the same cycle: flush wins and nothing is captured.
- Reset:
  - All registers clear to 0 at the next clk edge while reset=1.
  - Reset mid-operation drops any in-flight multiply with no output pulse afterwards.
  - Reset has priority over flush and A_en.
- When M_mul_valid=0 with A_en=1, a bubble advances and its data content is don't-care.
- A_mul_busy = S1_valid.

## Timing
- Reset values: A_mul_result = 32'h0, A_mul_result_valid = 0, A_mul_busy = 0.
- Latency is 2 enabled clk edges from M_mul_valid to A_mul_result_valid, for both low and high words.
- Throughput is one multiply per enabled cycle, with back-to-back issue allowed.
- Stalled cycles add latency one-for-one. Valid stays asserted on a held result across a stall.
- No combinational path from any input to any output.
- Critical path is the S2 four-operand 32-bit add. S1 holds the 34-bit three-operand add only.

## Test plan
- Unsigned low word: src1=3, src2=5, unsigned, mul_hi=0, partial products driven from the operands → A_mul_result=15 with valid exactly 2 cycles later.
- Unsigned high word (mulxuu): src1=src2=32'hFFFFFFFF → hi=32'hFFFFFFFE; the same operands with mul_hi=0 → 32'h00000001.
- Signed high words:
  - mulxss: src1=src2=32'hFFFFFFFF → 32'h00000000.
  - mulxsu: src1=32'hFFFFFFFE (signed) × src2=3 (unsigned) → hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- Back-to-back with stall: issue three multiplies on consecutive cycles, then hold A_en=0 for 3 cycles while S2 is valid → the result and valid are held. The results then appear in order on consecutive cycles with no loss or duplication.
- Flush and reset:
  - Assert A_flush in the cycle a multiply sits in S1 → no valid pulse; a multiply issued the following cycle completes normally.
  - Assert reset with two multiplies in flight → outputs are 0 and valid/busy are low from the next edge, with no stale pulse after reset is released.
- Randomized cross-check: 10k random operands × the 4 sign/hi combinations with random A_en stalls → every result matches a 64-bit reference product.
